// File: rtl/otter_hazard_ctrl.sv
// Purpose : OTTER 5-stage hazard control: load-use stall, redirect flush, EX forwarding, DE bypass, programmer drain/hold.
// Latency : stall/flush/bypass are combinational; fwd_*_sel and hold_ack are registered (hold_ack at t+DRAIN_CYC+1).
// Backpres: stalls PC and IF/DE with pc_write/if_de_write; injects DE/EX bubbles; freezes fetch while the programmer holds.
//
// Ports: CLK/RESET (sync, active-high); de_* describe the instruction in DE; ex_redirect marks a
// taken control transfer in EX; prog_hold requests a drained, frozen pipeline (acknowledged by
// hold_ack). Outputs drive the PC/IF-DE enables, IF/DE flush, DE/EX bubble, EX forwarding muxes
// (00 latched, 01 EX/MEM aluResult, 10 WB_rfIn), DE bypass from WB_rfIn, and saturating
// stall/flush counters.
module otter_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       de_rs1_addr,
    input  logic [4:0]       de_rs2_addr,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [4:0]       de_rd_addr,
    input  logic             de_regWrite,
    input  logic             de_memRead,
    input  logic             ex_redirect,
    input  logic             prog_hold,
    output logic             pc_write,
    output logic             if_de_write,
    output logic             if_de_flush,
    output logic             de_ex_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             de_byp_a,
    output logic             de_byp_b,
    output logic             hold_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} hold_state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    slot_t       ex_slot, mem_slot, wb_slot;
    hold_state_t state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic        hold_ack_q;
    logic        freeze, load_use, stall_evt, flush_evt;

    // x0 is hard-wired zero, so a write to it never produces a usable value.
    function automatic logic hits(input slot_t s, input logic [4:0] addr, input logic used);
        return s.vld && s.reg_write && (s.rd != 5'd0) && used && (s.rd == addr);
    endfunction

    // Nearest producer wins; a load still in EX has no data yet, so it never
    // selects the EX/MEM path (the load-use stall covers that case).
    function automatic logic [1:0] fwd_pick(input slot_t ex_s, input slot_t mem_s,
                                            input logic [4:0] addr, input logic used);
        if (hits(ex_s, addr, used) && !ex_s.mem_read)
            return 2'b01;
        else if (hits(mem_s, addr, used))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hold FSM next state. The drain counter leaves DRAIN on the edge where it reaches zero.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        unique case (state)
            RUN: begin
                if (prog_hold) begin
                    state_nxt = DRAIN;
                    drain_nxt = DW'(DRAIN_CYC);
                end
            end
            DRAIN: begin
                if (drain_cnt != '0)
                    drain_nxt = drain_cnt - DW'(1);
                if (drain_cnt <= DW'(1))
                    state_nxt = prog_hold ? HOLD : RUN;
            end
            HOLD: begin
                if (!prog_hold)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Pipeline control. Priority: reset, programmer freeze, redirect, load-use.
    // Fetch freezes in the very cycle prog_hold is first seen, not one cycle later.
    always_comb begin
        freeze       = (state != RUN) || prog_hold;
        load_use     = ex_slot.mem_read &&
                       (hits(ex_slot, de_rs1_addr, de_rs1_used) ||
                        hits(ex_slot, de_rs2_addr, de_rs2_used));
        pc_write     = 1'b1;
        if_de_write  = 1'b1;
        if_de_flush  = 1'b0;
        de_ex_bubble = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        if (RESET) begin
            if_de_flush  = 1'b1;
            de_ex_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_de_write  = 1'b0;
            if_de_flush  = 1'b1;
            de_ex_bubble = 1'b1;
        end else if (ex_redirect) begin
            // The DE instruction is wrong-path, so any load-use on it is moot.
            if_de_flush  = 1'b1;
            de_ex_bubble = 1'b1;
            flush_evt    = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_de_write  = 1'b0;
            de_ex_bubble = 1'b1;
            stall_evt    = 1'b1;
        end
    end

    assign de_byp_a = !RESET && hits(wb_slot, de_rs1_addr, de_rs1_used);
    assign de_byp_b = !RESET && hits(wb_slot, de_rs2_addr, de_rs2_used);
    assign hold_ack = hold_ack_q && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= RUN;
            drain_cnt  <= '0;
            hold_ack_q <= 1'b0;
            ex_slot    <= '0;
            mem_slot   <= '0;
            wb_slot    <= '0;
            fwd_a_sel  <= 2'b00;
            fwd_b_sel  <= 2'b00;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            drain_cnt  <= drain_nxt;
            hold_ack_q <= (state_nxt == HOLD);
            wb_slot    <= mem_slot;
            mem_slot   <= ex_slot;
            if (de_ex_bubble) begin
                ex_slot   <= '0;
                fwd_a_sel <= 2'b00;
                fwd_b_sel <= 2'b00;
            end else begin
                ex_slot   <= '{vld: 1'b1, rd: de_rd_addr, reg_write: de_regWrite, mem_read: de_memRead};
                fwd_a_sel <= fwd_pick(ex_slot, mem_slot, de_rs1_addr, de_rs1_used);
                fwd_b_sel <= fwd_pick(ex_slot, mem_slot, de_rs2_addr, de_rs2_used);
            end
            if (stall_evt && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/otter_hazard_ctrl.md
# otter_hazard_ctrl

Pipeline hazard controller for the five-stage OTTER RV32I core (IF, DE, EX, MEM, WB). It keeps a shadow pipeline of destination-register state for the instructions in EX, MEM and WB. From that state it generates PC/IF-DE write enables, bubble and flush controls, and EX-stage forwarding selects. It also drains and holds the pipeline on request from the serial programmer, and counts stall and flush cycles for debug.

## Interface
- `CNT_W`, default 16: width of the stall and flush counters.
- `DRAIN_CYC`, default 3: cycles of bubble injection before the pipeline counts as empty.

Ports:
- `CLK` in 1: the only clock.
- `RESET` in 1: synchronous reset, active-high.
- `de_rs1_addr`, `de_rs2_addr` in 5: source register addresses of the DE instruction.
- `de_rs1_used`, `de_rs2_used` in 1: DE instruction reads rs1 / rs2.
- `de_rd_addr` in 5: DE instruction destination register.
- `de_regWrite` in 1: DE instruction writes the register file.
- `de_memRead` in 1: DE instruction is a LOAD.
- `ex_redirect` in 1: EX resolved a taken branch, JAL, JALR or mret (pc_source ≠ 0).
- `prog_hold` in 1: programmer requests exclusive memory access.
- `pc_write` out 1: PC register load enable.
- `if_de_write` out 1: IF/DE register enable.
- `if_de_flush` out 1: replace IF/DE contents with a NOP.
- `de_ex_bubble` out 1: load a NOP (all write enables 0) into DE/EX.
- `fwd_a_sel`, `fwd_b_sel` out 2: EX operand source. 00 = latched value, 01 = EX/MEM aluResult, 10 = WB_rfIn.
- `de_byp_a`, `de_byp_b` out 1: in DE, select WB_rfIn instead of the RF read port.
- `hold_ack` out 1: pipeline is empty and frozen; programmer may proceed.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- **Shadow slots.** EX, MEM and WB each hold {valid, rd, regWrite, memRead}.
  - Every cycle: MEM→WB, EX→MEM.
  - EX receives the DE fields, or an invalid entry when `de_ex_bubble`=1.
- **Live producer.** A slot is a producer only when valid=1, regWrite=1 and rd≠0. x0 is never stalled on, forwarded or bypassed.
- **Load-use stall.** Condition: the EX slot holds a live LOAD whose rd equals a DE source with its used bit set.
  - Outputs: `pc_write`=0, `if_de_write`=0, `de_ex_bubble`=1. Exactly one cycle.
  - The counter `stall_cnt` increments.
- **Redirect.** `ex_redirect`=1 gives `pc_write`=1, `if_de_flush`=1, `de_ex_bubble`=1, and increments `flush_cnt`.
  - Redirect overrides a simultaneous load-use stall; the stalled DE instruction is on the wrong path and is discarded.
- **Forwarding selects.** Computed for the DE instruction and registered when DE→EX advances, so they are valid while that instruction is in EX.
  - 01 when the EX slot (which becomes MEM) is a live non-load match.
  - Otherwise 10 when the MEM slot (which becomes WB) is a live match.
  - Otherwise 00.
  - The nearest producer wins.
  - A bubble cycle registers 00.
- **DE bypass.** `de_byp_a`/`de_byp_b` are combinational. They are 1 when the WB slot is a live match for rs1/rs2 with the used bit set.
- **Hold FSM**, states RUN, DRAIN, HOLD:
  - RUN→DRAIN on `prog_hold`=1.
  - In DRAIN, a down-counter loaded with DRAIN_CYC runs. `pc_write`=0, `if_de_write`=0, `if_de_flush`=1, `de_ex_bubble`=1.
  - DRAIN→HOLD when the counter reaches 0 and `prog_hold`=1.
  - DRAIN→RUN when the counter reaches 0 and `prog_hold`=0.
  - In HOLD, the same freeze outputs apply and `hold_ack`=1.
  - HOLD→RUN when `prog_hold`=0.
  - An `ex_redirect` during DRAIN is ignored, because fetch is already suppressed and the instruction in EX still completes.
- **Counters.** Saturate at all-ones. They do not count in DRAIN or HOLD.

## Timing
- **While RESET=1**, at the clock edge: slots become invalid, the FSM goes to RUN, `fwd_*_sel`=00, counters=0, the drain counter=0.
- **Output values while RESET=1** (combinational): `pc_write`=1, `if_de_write`=1, `if_de_flush`=1, `de_ex_bubble`=1, `hold_ack`=0, `de_byp_*`=0.
- **Output values after reset with no hazards:** `pc_write`=`if_de_write`=1; flush, bubble and bypass = 0.
- **Combinational outputs:** stall, flush and bypass outputs are combinational from slots, FSM state and DE/EX inputs, with no added latency.
- **Registered outputs:** `fwd_*_sel` and `hold_ack` are registered.
- **Hold latency:** `prog_hold` rising in cycle t gives `hold_ack`=1 from cycle t+DRAIN_CYC+1. `prog_hold` falling in HOLD gives `pc_write`=1 the next cycle.
- **Reset mid-DRAIN or mid-HOLD:** return to RUN with `hold_ack`=0 immediately after the edge.
- **Load-use:** the consumer enters EX two cycles after the load enters EX, with select 10.

## Test plan
- **Back-to-back ALU.** Sequence: `add x5,x1,x2` then `sub x6,x5,x3`. Required: `fwd_a_sel`=01 during sub in EX, no stall, `stall_cnt`=0.
- **Load-use.** Sequence: `lw x7,0(x1)` then `add x8,x7,x7`. Required: one cycle with `pc_write`=0 and `de_ex_bubble`=1; then `fwd_a_sel`=`fwd_b_sel`=10; `stall_cnt`=1. Repeat with rd=x0: no stall.
- **Distance-3 and priority.**
  - Producer three ahead: `de_byp_a`=1.
  - Two producers of x9 at distances 1 and 2: select 01, not 10.
- **Redirect with stall.** A taken BEQ in EX in the same cycle as a load-use condition. Required: `if_de_flush`=1, `de_ex_bubble`=1, `pc_write`=1, `flush_cnt`=1, `stall_cnt`=0.
- **Programmer hold.**
  - Assert `prog_hold` at cycle 10: `hold_ack`=1 at cycle 14, `pc_write`=0 on cycles 10–14+.
  - Deassert at cycle 20: `pc_write`=1 at cycle 21.
  - Pulse `prog_hold` for one cycle: the FSM returns to RUN after DRAIN and `hold_ack` never rises.
- **Reset and saturation.**
  - Assert RESET during HOLD: outputs return to their reset values after one edge.
  - With CNT_W=4 and 20 load-use stalls: `stall_cnt`=15.
